// File: rtl/sm83_bus_unit.sv
// sm83_bus_unit: M-cycle bus interface unit. Arbitrates N_CH requesters onto a
// single memory port and stretches every access to T_PER_M clocks plus
// cfg_wait wait clocks plus however long mem_ready stays low at the end.
//
// Ports
//   clk, rst_n              clock / async active-low reset
//   req_valid/_ready/_we    per-channel handshake and direction
//   req_addr, req_wdata     packed per-channel fields, ch i at [i*W +: W]
//   cfg_wait                extra wait clocks, captured when a request is accepted
//   rsp_valid, rsp_rdata    one-clock completion pulse + registered read data
//   mem_*                   memory port (ren held through a read, wen one clock)
//   busy                    access in flight
module sm83_bus_unit #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int N_CH     = 2,
  parameter int T_PER_M  = 4,
  parameter int WAIT_W   = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          req_valid,
  output logic [N_CH-1:0]          req_ready,
  input  logic [N_CH-1:0]          req_we,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  input  logic [WAIT_W-1:0]        cfg_wait,
  output logic [N_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_ren,
  output logic                     mem_wen,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ready,
  output logic                     busy
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW = $clog2(T_PER_M);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       ch_q, ptr_q, gnt_idx;
  logic                gnt_any;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WAIT_W-1:0]   wait_q, wcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic [N_CH-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                end_phase, complete, accept;

  // Candidate channel for search position k. Round-robin starts one past the
  // last granted channel so every requester gets a turn.
  function automatic logic [CW-1:0] cand(input int k, input logic [CW-1:0] ptr);
    if (ARB_MODE == 1) return CW'((int'(ptr) + 1 + k) % N_CH);
    else               return CW'(k);
  endfunction

  // End phase: all T clocks done and wcnt has caught up with the captured
  // wait count; the access then sits here until memory is ready.
  assign end_phase = (state_q == S_ACCESS) && (tcnt_q == TW'(T_PER_M - 1)) &&
                     (wcnt_q == wait_q);
  assign complete  = end_phase && mem_ready;
  assign accept    = ((state_q == S_IDLE) || complete) && gnt_any;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_any && req_valid[cand(k, ptr_q)]) begin
        gnt_any = 1'b1;
        gnt_idx = cand(k, ptr_q);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: if (complete) state_d = accept ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    if (complete) rsp_valid_d[ch_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q        <= '0;
      ptr_q       <= CW'(N_CH - 1);
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      tcnt_q      <= '0;
      wcnt_q      <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (complete && !we_q) rsp_rdata_q <= mem_rdata;
      if (accept) begin
        ch_q    <= gnt_idx;
        ptr_q   <= gnt_idx;
        we_q    <= req_we[gnt_idx];
        addr_q  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
        wait_q  <= cfg_wait;
        tcnt_q  <= '0;
        wcnt_q  <= '0;
      end else if (state_q == S_ACCESS && !end_phase) begin
        if (tcnt_q != TW'(T_PER_M - 1)) tcnt_q <= tcnt_q + TW'(1);
        else                            wcnt_q <= wcnt_q + WAIT_W'(1);
      end
    end
  end

  // Strobes are decoded from live state so an async reset drops them at once.
  assign busy      = (state_q == S_ACCESS);
  assign mem_ren   = busy && !we_q;
  assign mem_wen   = complete && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
